// File: rtl/regfile_param.sv
// Parametrised register file: DEPTH x WIDTH storage with one synchronous write
// port, two combinational read ports, optional write-through bypass, optional
// hardwired-zero entry 0, and a per-entry busy scoreboard for RAW detection.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous reset, active-low
//   wren/waddr/wdata write port (writeback)
//   raddr1/raddr2    read addresses (decode)
//   rdata1/rdata2    combinational read data
//   rsv_en/rsv_addr  reserve an entry for an in-flight producer
//   flush            clear every busy bit
//   busy1/busy2      pending-write flag of the entry at raddr1/raddr2
//   busy_any         OR of all registered busy bits
module regfile_param #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             flush,
    output logic             busy1,
    output logic             busy2,
    output logic             busy_any
);

    localparam bit HAS_BYPASS = (BYPASS != 0);
    localparam bit HAS_ZERO   = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             wr_ok;
    logic             byp1;
    logic             byp2;

    // Writes to the hardwired-zero entry are dropped.
    assign wr_ok = wren && !(HAS_ZERO && (waddr == '0));

    // Scoreboard next state: flush beats everything; a same-address reserve
    // beats the completing write because the new producer is still in flight.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wren && !(rsv_en && (rsv_addr == waddr))) begin
                busy_nxt[waddr] = 1'b0;
            end
            if (rsv_en) begin
                busy_nxt[rsv_addr] = 1'b1;
            end
        end
        if (HAS_ZERO) begin
            busy_nxt[0] = 1'b0;
        end
    end

    // Storage and scoreboard registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem  <= '{default: '0};
            busy <= '0;
        end else begin
            if (wr_ok) begin
                mem[waddr] <= wdata;
            end
            busy <= busy_nxt;
        end
    end

    // Bypass is gated by rst so reads show zero while reset is held.
    assign byp1 = HAS_BYPASS && rst && wren && (waddr == raddr1);
    assign byp2 = HAS_BYPASS && rst && wren && (waddr == raddr2);

    // Read ports: storage, then forwarded write data, then the zero override.
    always_comb begin
        rdata1 = mem[raddr1];
        if (byp1) begin
            rdata1 = wdata;
        end
        if (HAS_ZERO && (raddr1 == '0)) begin
            rdata1 = '0;
        end
    end

    always_comb begin
        rdata2 = mem[raddr2];
        if (byp2) begin
            rdata2 = wdata;
        end
        if (HAS_ZERO && (raddr2 == '0)) begin
            rdata2 = '0;
        end
    end

    // A completing write being forwarded hides the busy flag from decode.
    assign busy1    = busy[raddr1] & ~byp1;
    assign busy2    = busy[raddr2] & ~byp2;
    assign busy_any = |busy;

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: a default instance (bypass, no zero entry)
// driven by a vector table, plus instances built without bypass, with a
// hardwired-zero entry, and at 32x32 for a full-depth sweep.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wren, rsv_en, flush;
    logic [3:0]  waddr, raddr1, raddr2, rsv_addr;
    logic [15:0] wdata;

    logic [15:0] rd1, rd2, nb_rd1, nb_rd2, z_rd1, z_rd2;
    logic        b1, b2, bany, nb_b1, nb_b2, nb_bany, z_b1, z_b2, z_bany;

    logic        w_wren;
    logic [4:0]  w_waddr, w_ra1, w_ra2;
    logic [31:0] w_wdata, w_rd1, w_rd2;
    logic        w_b1, w_b2, w_bany;

    int unsigned passes = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    regfile_param u_dut (
        .clk(clk), .rst(rst), .wren(wren), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1), .rdata2(rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy1(b1), .busy2(b2), .busy_any(bany)
    );

    regfile_param #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .wren(wren), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rd1), .rdata2(nb_rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy1(nb_b1), .busy2(nb_b2), .busy_any(nb_bany)
    );

    regfile_param #(.ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .wren(wren), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rd1), .rdata2(z_rd2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
        .busy1(z_b1), .busy2(z_b2), .busy_any(z_bany)
    );

    regfile_param #(.WIDTH(32), .DEPTH(32)) u_w (
        .clk(clk), .rst(rst), .wren(w_wren), .waddr(w_waddr), .wdata(w_wdata),
        .raddr1(w_ra1), .raddr2(w_ra2), .rdata1(w_rd1), .rdata2(w_rd2),
        .rsv_en(1'b0), .rsv_addr(5'd0), .flush(1'b0),
        .busy1(w_b1), .busy2(w_b2), .busy_any(w_bany)
    );

    typedef struct {
        logic        wren;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic        rsv;
        logic [3:0]  rsva;
        logic        flush;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
        logic        e_any;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [3:0] wa, logic [15:0] wd,
                                logic [3:0] a1, logic [3:0] a2,
                                logic rv, logic [3:0] rva, logic fl,
                                logic [15:0] e1, logic [15:0] e2,
                                logic eb1, logic eb2, logic ea);
        vec_t v;
        v.wren = we;  v.waddr = wa; v.wdata = wd;
        v.ra1 = a1;   v.ra2 = a2;
        v.rsv = rv;   v.rsva = rva; v.flush = fl;
        v.e_rd1 = e1; v.e_rd2 = e2;
        v.e_b1 = eb1; v.e_b2 = eb2; v.e_any = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic idle();
        wren = 1'b0; waddr = '0; wdata = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        raddr1 = '0; raddr2 = '0;
    endtask

    initial begin
        idle();
        w_wren = 1'b0; w_waddr = '0; w_wdata = '0; w_ra1 = '0; w_ra2 = '0;

        //        we wa  wdata     a1 a2 rv rva fl  e_rd1     e_rd2     b1 b2 any
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 7, 16'h1234, 7, 7, 0, 0, 0, 16'h1234, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 7, 0, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 4, 7, 1, 4, 0, 16'h0000, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 4, 7, 0, 0, 0, 16'h0000, 16'h1234, 1, 0, 1));
        vecs.push_back(mk(1, 4, 16'h00AA, 4, 7, 0, 0, 0, 16'h00AA, 16'h1234, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 4, 4, 0, 0, 0, 16'h00AA, 16'h00AA, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 9, 4, 1, 9, 0, 16'h0000, 16'h00AA, 0, 0, 0));
        vecs.push_back(mk(1, 9, 16'h0042, 9, 2, 1, 9, 0, 16'h0042, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 9, 2, 0, 0, 0, 16'h0042, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(1, 9, 16'h0043, 9, 2, 1, 2, 0, 16'h0043, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 9, 2, 0, 0, 0, 16'h0043, 16'h0000, 0, 1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 3, 1, 3, 0, 16'h0000, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 6, 1, 6, 1, 16'h0000, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 3, 6, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 5, 2, 1, 5, 0, 16'h0000, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 5, 2, 1, 5, 0, 16'h0000, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 5, 2, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(1, 8, 16'h0808, 8, 5, 0, 0, 0, 16'h0808, 16'h0000, 0, 1, 1));
        vecs.push_back(mk(1, 5, 16'h0055, 8, 5, 0, 0, 0, 16'h0808, 16'h0055, 0, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 8, 5, 0, 0, 0, 16'h0808, 16'h0055, 0, 0, 0));

        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Table: inputs applied after the falling edge, outputs checked
        // before the following rising edge commits them.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            wren = vecs[i].wren; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr1 = vecs[i].ra1; raddr2 = vecs[i].ra2;
            rsv_en = vecs[i].rsv; rsv_addr = vecs[i].rsva; flush = vecs[i].flush;
            #1;
            chk($sformatf("v%0d rdata1", i), 32'(rd1), 32'(vecs[i].e_rd1));
            chk($sformatf("v%0d rdata2", i), 32'(rd2), 32'(vecs[i].e_rd2));
            chk($sformatf("v%0d busy1", i), 32'(b1), 32'(vecs[i].e_b1));
            chk($sformatf("v%0d busy2", i), 32'(b2), 32'(vecs[i].e_b2));
            chk($sformatf("v%0d busy_any", i), 32'(bany), 32'(vecs[i].e_any));
        end

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        idle(); wren = 1'b1; waddr = 4'd3; wdata = 16'hBEEF; rsv_en = 1'b1; rsv_addr = 4'd5;
        @(negedge clk);
        idle(); raddr1 = 4'd3; raddr2 = 4'd5;
        #1;
        chk("pre-reset rdata1", 32'(rd1), 32'h0000BEEF);
        chk("pre-reset busy2", 32'(b2), 32'd1);
        rst = 1'b0;
        #1;
        chk("async reset rdata1", 32'(rd1), 32'd0);
        chk("async reset busy2", 32'(b2), 32'd0);
        chk("async reset busy_any", 32'(bany), 32'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset rdata1", 32'(rd1), 32'd0);

        // Bypass versus no-bypass build.
        @(negedge clk);
        idle(); wren = 1'b1; waddr = 4'd7; wdata = 16'h1234; raddr1 = 4'd7; raddr2 = 4'd7;
        #1;
        chk("nb same-cycle rdata1", 32'(nb_rd1), 32'd0);
        chk("nb same-cycle rdata2", 32'(nb_rd2), 32'd0);
        chk("byp same-cycle rdata1", 32'(rd1), 32'h00001234);
        @(negedge clk);
        idle(); raddr1 = 4'd7; raddr2 = 4'd7;
        #1;
        chk("nb next-cycle rdata1", 32'(nb_rd1), 32'h00001234);
        chk("nb next-cycle rdata2", 32'(nb_rd2), 32'h00001234);
        @(negedge clk);
        idle(); rsv_en = 1'b1; rsv_addr = 4'd4;
        @(negedge clk);
        idle(); wren = 1'b1; waddr = 4'd4; wdata = 16'h00AA; raddr1 = 4'd4;
        #1;
        chk("nb completing busy1", 32'(nb_b1), 32'd1);
        chk("nb completing rdata1", 32'(nb_rd1), 32'd0);
        chk("byp completing busy1", 32'(b1), 32'd0);
        chk("byp completing rdata1", 32'(rd1), 32'h000000AA);
        @(negedge clk);
        idle(); raddr1 = 4'd4;
        #1;
        chk("nb after write busy1", 32'(nb_b1), 32'd0);
        chk("nb after write rdata1", 32'(nb_rd1), 32'h000000AA);
        chk("nb after write busy_any", 32'(nb_bany), 32'd0);

        // Hardwired-zero entry.
        @(negedge clk);
        idle(); wren = 1'b1; waddr = 4'd0; wdata = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 4'd0;
        #1;
        chk("zero same-cycle rdata1", 32'(z_rd1), 32'd0);
        chk("zero same-cycle busy1", 32'(z_b1), 32'd0);
        chk("nozero same-cycle rdata1", 32'(rd1), 32'h0000FFFF);
        @(negedge clk);
        idle();
        #1;
        chk("zero rdata1", 32'(z_rd1), 32'd0);
        chk("zero busy1", 32'(z_b1), 32'd0);
        chk("zero busy_any", 32'(z_bany), 32'd0);
        chk("nozero rdata1", 32'(rd1), 32'h0000FFFF);
        chk("nozero busy1", 32'(b1), 32'd1);
        @(negedge clk);
        idle(); wren = 1'b1; waddr = 4'd1; wdata = 16'h5555; raddr1 = 4'd1;
        #1;
        chk("zero build entry1 bypass", 32'(z_rd1), 32'h00005555);

        // Full-depth sweep on the 32x32 build.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            idle();
            w_wren = 1'b1; w_waddr = 5'(i); w_wdata = 32'(i * 3);
        end
        @(negedge clk);
        w_wren = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            w_ra1 = 5'(i); w_ra2 = 5'(31 - i);
            #1;
            chk($sformatf("sweep rdata1[%0d]", i), w_rd1, 32'(i * 3));
            chk($sformatf("sweep rdata2[%0d]", 31 - i), w_rd2, 32'((31 - i) * 3));
        end
        chk("sweep busy_any", 32'(w_bany), 32'd0);
        chk("sweep busy1", 32'(w_b1), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
